// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instructions, forwards EX/MEM and
// MEM/WB results into the ALU operands, and raises a stall on load-use hazards.
module id_ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [2:0]  id_rs1,
    input  logic [2:0]  id_rs2,
    input  logic [2:0]  id_rd,
    input  logic [15:0] id_rs1_val,
    input  logic [15:0] id_rs2_val,
    input  logic [15:0] id_imm,
    input  logic        id_alu_src,
    input  logic [2:0]  id_alu_control,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        mem_reg_write,
    input  logic [2:0]  mem_rd,
    input  logic [15:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [2:0]  wb_rd,
    input  logic [15:0] wb_result,
    output logic        stall,
    output logic [15:0] entrada1,
    output logic [15:0] entrada2,
    output logic [2:0]  ALUControl,
    output logic        ex_valid,
    output logic [2:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [15:0] ex_store_data
);

    logic        valid_q;
    logic [2:0]  rs1_q, rs2_q, rd_q;
    logic [15:0] rs1_val_q, rs2_val_q, imm_q;
    logic        alu_src_q;
    logic [2:0]  alu_control_q;
    logic        reg_write_q, mem_read_q, mem_write_q;

    logic        rs2_used;
    logic [15:0] fwd_rs1, fwd_rs2;

    // Only the EX-resident instruction's registered state feeds stall, never mem/wb.
    assign rs2_used = ~id_alu_src | id_mem_write;
    assign stall    = id_valid & valid_q & mem_read_q & (rd_q != 3'd0) &
                      ((id_rs1 == rd_q) | (rs2_used & (id_rs2 == rd_q)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            rs1_q         <= 3'd0;
            rs2_q         <= 3'd0;
            rd_q          <= 3'd0;
            rs1_val_q     <= 16'd0;
            rs2_val_q     <= 16'd0;
            imm_q         <= 16'd0;
            alu_src_q     <= 1'b0;
            alu_control_q <= 3'd0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            rs1_q     <= id_rs1;
            rs2_q     <= id_rs2;
            rd_q      <= id_rd;
            rs1_val_q <= id_rs1_val;
            rs2_val_q <= id_rs2_val;
            imm_q     <= id_imm;
            alu_src_q <= id_alu_src;
            if (flush || stall) begin
                valid_q       <= 1'b0;
                alu_control_q <= 3'd0;
                reg_write_q   <= 1'b0;
                mem_read_q    <= 1'b0;
                mem_write_q   <= 1'b0;
            end else begin
                valid_q       <= id_valid;
                alu_control_q <= id_alu_control;
                reg_write_q   <= id_reg_write;
                mem_read_q    <= id_mem_read;
                mem_write_q   <= id_mem_write;
            end
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_val_q;
        if (mem_reg_write && (mem_rd != 3'd0) && (mem_rd == rs1_q))
            fwd_rs1 = mem_result;
        else if (wb_reg_write && (wb_rd != 3'd0) && (wb_rd == rs1_q))
            fwd_rs1 = wb_result;
    end

    always_comb begin
        fwd_rs2 = rs2_val_q;
        if (mem_reg_write && (mem_rd != 3'd0) && (mem_rd == rs2_q))
            fwd_rs2 = mem_result;
        else if (wb_reg_write && (wb_rd != 3'd0) && (wb_rd == rs2_q))
            fwd_rs2 = wb_result;
    end

    assign entrada1      = fwd_rs1;
    assign entrada2      = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ALUControl    = valid_q ? alu_control_q : 3'd0;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_mem_read   = mem_read_q & valid_q;
    assign ex_mem_write  = mem_write_q & valid_q;

endmodule
